// File: rtl/sm4_rk_buffer.sv
// sm4_rk_buffer
//   Round-key store between the SM4 key-expansion datapath (writer) and the
//   iterative SM4 round engine (reader). Captures rk0..rk31 as they are
//   produced and replays them once per round, forward for encryption or
//   reversed for decryption. One load serves any number of block passes.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load_start    begin a new key load (discards the stored set)
//   rk_wr_en      rk_wr_data valid this cycle
//   rk_wr_data    round key rk[i], presented in order i = 0..31
//   key_ready     full set of 32 keys stored
//   rd_start      begin a block pass (needs key_ready and no pass running)
//   rd_dir        sampled with rd_start: 0 = rk0..rk31, 1 = rk31..rk0
//   rd_next       round engine consumed rk_out; advance
//   rk_out        round key for the current round, 0 when idle
//   rk_round      logical round number of rk_out
//   rd_busy       a pass is in progress
//   rd_done       one-cycle pulse after the final key is consumed
//   err           one-cycle pulse on any rejected request
module sm4_rk_buffer #(
  parameter int RK_WIDTH = 32,
  parameter int ROUNDS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                rk_wr_en,
  input  logic [RK_WIDTH-1:0] rk_wr_data,
  output logic                key_ready,
  input  logic                rd_start,
  input  logic                rd_dir,
  input  logic                rd_next,
  output logic [RK_WIDTH-1:0] rk_out,
  output logic [4:0]          rk_round,
  output logic                rd_busy,
  output logic                rd_done,
  output logic                err
);

  localparam logic [4:0] LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    L_EMPTY   = 2'd0,
    L_LOADING = 2'd1,
    L_READY   = 2'd2
  } load_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  logic [RK_WIDTH-1:0] key_mem [ROUNDS];

  load_state_t         load_state, load_state_nxt;
  rd_state_t           rd_state, rd_state_nxt;
  logic [4:0]          wr_idx, wr_idx_nxt;
  logic [4:0]          rd_idx, rd_idx_nxt;
  logic                dir, dir_nxt;
  logic [4:0]          round_nxt;
  logic [RK_WIDTH-1:0] rk_out_nxt;
  logic                done_nxt;
  logic                err_nxt;

  logic load_ok, wr_ok, wr_rej, rd_ok, rd_rej, adv;

  // Request qualification, next-state and next-output logic for both FSMs
  always_comb begin
    // a load may not pull the key set out from under a running pass
    load_ok = load_start && (rd_state == R_IDLE);
    // a restart in the same cycle wins over the write, silently
    wr_ok   = rk_wr_en && (load_state == L_LOADING) && !load_start;
    wr_rej  = rk_wr_en && (load_state != L_LOADING);
    // an accompanying load_start wins over rd_start
    rd_ok   = rd_start && (load_state == L_READY) && (rd_state == R_IDLE) && !load_start;
    rd_rej  = rd_start && !rd_ok;
    adv     = rd_next && (rd_state == R_RUN);
    err_nxt = wr_rej || rd_rej || (load_start && !load_ok);

    load_state_nxt = load_state;
    wr_idx_nxt     = wr_idx;
    if (load_ok) begin
      load_state_nxt = L_LOADING;
      wr_idx_nxt     = 5'd0;
    end else begin
      case (load_state)
        L_LOADING: begin
          if (wr_ok) begin
            wr_idx_nxt = wr_idx + 5'd1;
            if (wr_idx == LAST_IDX) begin
              load_state_nxt = L_READY;
            end else begin
              load_state_nxt = L_LOADING;
            end
          end else begin
            load_state_nxt = L_LOADING;
          end
        end
        L_EMPTY: load_state_nxt = L_EMPTY;
        L_READY: load_state_nxt = L_READY;
        default: load_state_nxt = L_EMPTY;
      endcase
    end

    rd_state_nxt = rd_state;
    rd_idx_nxt   = rd_idx;
    dir_nxt      = dir;
    round_nxt    = rk_round;
    done_nxt     = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (rd_ok) begin
          rd_state_nxt = R_RUN;
          dir_nxt      = rd_dir;
          rd_idx_nxt   = rd_dir ? LAST_IDX : 5'd0;
          round_nxt    = 5'd0;
        end else begin
          rd_state_nxt = R_IDLE;
        end
      end
      R_RUN: begin
        if (adv) begin
          if (rk_round == LAST_IDX) begin
            rd_state_nxt = R_IDLE;
            rd_idx_nxt   = 5'd0;
            round_nxt    = 5'd0;
            done_nxt     = 1'b1;
          end else begin
            round_nxt  = rk_round + 5'd1;
            rd_idx_nxt = dir ? (rd_idx - 5'd1) : (rd_idx + 5'd1);
          end
        end else begin
          rd_state_nxt = R_RUN;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase

    // the array is only written while LOADING, which never overlaps a pass
    if (rd_state_nxt == R_RUN) begin
      rk_out_nxt = key_mem[rd_idx_nxt];
    end else begin
      rk_out_nxt = {RK_WIDTH{1'b0}};
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      load_state <= L_EMPTY;
      rd_state   <= R_IDLE;
      wr_idx     <= 5'd0;
      rd_idx     <= 5'd0;
      dir        <= 1'b0;
      rk_round   <= 5'd0;
      rk_out     <= {RK_WIDTH{1'b0}};
      key_ready  <= 1'b0;
      rd_busy    <= 1'b0;
      rd_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      load_state <= load_state_nxt;
      rd_state   <= rd_state_nxt;
      wr_idx     <= wr_idx_nxt;
      rd_idx     <= rd_idx_nxt;
      dir        <= dir_nxt;
      rk_round   <= round_nxt;
      rk_out     <= rk_out_nxt;
      key_ready  <= (load_state_nxt == L_READY);
      rd_busy    <= (rd_state_nxt == R_RUN);
      rd_done    <= done_nxt;
      err        <= err_nxt;
    end
  end

  // Key array; contents are unreadable until a full load completes, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_mem[wr_idx] <= rk_wr_data;
    end
  end

endmodule

// File: tb/tb_sm4_rk_buffer.sv
module tb_sm4_rk_buffer;

  logic        clk = 1'b0;
  logic        rst, load_start, rk_wr_en, rd_start, rd_dir, rd_next;
  logic [31:0] rk_wr_data;
  logic        key_ready, rd_busy, rd_done, err;
  logic [31:0] rk_out;
  logic [4:0]  rk_round;

  always #5 clk = ~clk;

  sm4_rk_buffer dut (
    .clk(clk), .rst(rst), .load_start(load_start), .rk_wr_en(rk_wr_en),
    .rk_wr_data(rk_wr_data), .key_ready(key_ready), .rd_start(rd_start),
    .rd_dir(rd_dir), .rd_next(rd_next), .rk_out(rk_out), .rk_round(rk_round),
    .rd_busy(rd_busy), .rd_done(rd_done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [32];

  typedef struct {
    logic [31:0] key;
    logic [4:0]  rnd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic ls, wr, rs, rn;
    logic e_err, e_busy, e_ready;
  } vec_t;
  vec_t vecs[8];

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_front();
    chk("rk_out", rk_out, exp_q[0].key);
    chk("rk_round", {27'd0, rk_round}, {27'd0, exp_q[0].rnd});
  endtask

  task automatic write_keys(input logic [31:0] base, input int gapmax);
    for (int i = 0; i < 32; i++) begin
      int g;
      g = $urandom_range(gapmax, 0);
      repeat (g) step();
      rk_wr_en   = 1'b1;
      rk_wr_data = base + i;
      model_mem[i] = base + i;
      step();
      rk_wr_en = 1'b0;
      if (i == 30) chk("ready_before_last", {31'd0, key_ready}, 32'd0);
    end
    chk("ready_after_last", {31'd0, key_ready}, 32'd1);
  endtask

  task automatic load_keys(input logic [31:0] base, input int gapmax);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("loading_not_ready", {31'd0, key_ready}, 32'd0);
    write_keys(base, gapmax);
  endtask

  // One full pass; expected keys go on the scoreboard at rd_start
  task automatic pass(input logic dir, input int gapmax, input int inj_k);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      e.key = model_mem[dir ? (31 - k) : k];
      e.rnd = 5'(k);
      exp_q.push_back(e);
    end
    rd_start = 1'b1;
    rd_dir   = dir;
    step();
    rd_start = 1'b0;
    chk("start_busy", {31'd0, rd_busy}, 32'd1);
    chk("start_err", {31'd0, err}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      int g;
      g = $urandom_range(gapmax, 0);
      repeat (g) begin
        chk_front();
        step();
      end
      if (k == inj_k) begin
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_in_pass_err", {31'd0, err}, 32'd1);
        chk("load_in_pass_busy", {31'd0, rd_busy}, 32'd1);
      end
      chk_front();
      rd_next = 1'b1;
      step();
      rd_next = 1'b0;
      void'(exp_q.pop_front());
    end
    chk("end_done", {31'd0, rd_done}, 32'd1);
    chk("end_busy", {31'd0, rd_busy}, 32'd0);
    chk("end_rk_out", rk_out, 32'd0);
    chk("end_round", {27'd0, rk_round}, 32'd0);
    step();
    chk("done_falls", {31'd0, rd_done}, 32'd0);
  endtask

  initial begin
    // single-cycle requests applied from READY with no pass running
    vecs[0] = '{ls:1'b0, wr:1'b1, rs:1'b0, rn:1'b0, e_err:1'b1, e_busy:1'b0, e_ready:1'b1};
    vecs[1] = '{ls:1'b0, wr:1'b0, rs:1'b0, rn:1'b1, e_err:1'b0, e_busy:1'b0, e_ready:1'b1};
    vecs[2] = '{ls:1'b0, wr:1'b0, rs:1'b0, rn:1'b0, e_err:1'b0, e_busy:1'b0, e_ready:1'b1};
    vecs[3] = '{ls:1'b0, wr:1'b1, rs:1'b0, rn:1'b1, e_err:1'b1, e_busy:1'b0, e_ready:1'b1};
    vecs[4] = '{ls:1'b0, wr:1'b0, rs:1'b1, rn:1'b1, e_err:1'b0, e_busy:1'b1, e_ready:1'b1};
    vecs[5] = '{ls:1'b0, wr:1'b0, rs:1'b1, rn:1'b0, e_err:1'b1, e_busy:1'b1, e_ready:1'b1};
    vecs[6] = '{ls:1'b1, wr:1'b0, rs:1'b0, rn:1'b0, e_err:1'b1, e_busy:1'b1, e_ready:1'b1};
    vecs[7] = '{ls:1'b1, wr:1'b1, rs:1'b1, rn:1'b0, e_err:1'b1, e_busy:1'b1, e_ready:1'b1};

    rst = 1'b1; load_start = 1'b0; rk_wr_en = 1'b0; rk_wr_data = 32'd0;
    rd_start = 1'b0; rd_dir = 1'b0; rd_next = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_key_ready", {31'd0, key_ready}, 32'd0);
    chk("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
    chk("rst_rd_done", {31'd0, rd_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rk_out", rk_out, 32'd0);
    chk("rst_rk_round", {27'd0, rk_round}, 32'd0);

    // read before any key load
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("early_rd_err", {31'd0, err}, 32'd1);
    chk("early_rd_busy", {31'd0, rd_busy}, 32'd0);
    step();
    chk("err_one_cycle", {31'd0, err}, 32'd0);

    // gap-free load, forward, reverse, forward again
    load_keys(32'hA5000000, 0);
    pass(1'b0, 0, -1);
    pass(1'b1, 0, -1);
    pass(1'b0, 0, -1);

    // table of single-cycle requests
    for (int i = 0; i < 8; i++) begin
      load_start = vecs[i].ls;
      rk_wr_en   = vecs[i].wr;
      rk_wr_data = 32'hDEADBEEF;
      rd_start   = vecs[i].rs;
      rd_next    = vecs[i].rn;
      rd_dir     = 1'b0;
      step();
      load_start = 1'b0; rk_wr_en = 1'b0; rd_start = 1'b0; rd_next = 1'b0;
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
      chk($sformatf("vec%0d_busy", i), {31'd0, rd_busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d_ready", i), {31'd0, key_ready}, {31'd0, vecs[i].e_ready});
    end
    // drain the pass opened by vec4; rejected writes must not have touched the array
    chk("tbl_first_key", rk_out, 32'hA5000000);
    chk("tbl_first_round", {27'd0, rk_round}, 32'd0);
    rd_next = 1'b1;
    repeat (32) step();
    rd_next = 1'b0;
    chk("tbl_done", {31'd0, rd_done}, 32'd1);
    step();

    // load_start mid-pass is rejected and the pass completes; array intact
    pass(1'b0, 0, 5);
    chk("ready_after_inj", {31'd0, key_ready}, 32'd1);

    // load_start together with rd_start from READY: load wins
    load_start = 1'b1;
    rd_start   = 1'b1;
    step();
    load_start = 1'b0;
    rd_start   = 1'b0;
    chk("ls_rs_err", {31'd0, err}, 32'd1);
    chk("ls_rs_busy", {31'd0, rd_busy}, 32'd0);
    chk("ls_rs_ready", {31'd0, key_ready}, 32'd0);

    // gapped load and gapped reads
    write_keys(32'hA5000000, 3);
    pass(1'b0, 3, -1);
    pass(1'b1, 3, -1);

    // restart after 10 writes, restart cycle carries a write
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rk_wr_en   = 1'b1;
      rk_wr_data = 32'hDEAD0000 + i;
      step();
    end
    load_start = 1'b1;
    rk_wr_data = 32'hDEAD00FF;
    step();
    load_start = 1'b0;
    rk_wr_en   = 1'b0;
    chk("restart_err", {31'd0, err}, 32'd0);
    chk("restart_ready", {31'd0, key_ready}, 32'd0);
    write_keys(32'h5A000000, 0);
    pass(1'b0, 0, -1);

    // reset in the middle of a pass
    rd_start = 1'b1;
    rd_dir   = 1'b0;
    step();
    rd_start = 1'b0;
    rd_next  = 1'b1;
    repeat (7) step();
    rd_next = 1'b0;
    chk("pre_rst_round", {27'd0, rk_round}, 32'd7);
    chk("pre_rst_key", rk_out, 32'h5A000007);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, rd_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, key_ready}, 32'd0);
    chk("mid_rst_rk_out", rk_out, 32'd0);
    chk("mid_rst_round", {27'd0, rk_round}, 32'd0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("post_rst_rd_err", {31'd0, err}, 32'd1);
    chk("post_rst_rd_busy", {31'd0, rd_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm4_rk_buffer.md
# sm4_rk_buffer

Round-key store between the SM4 key-expansion datapath (writer) and the iterative SM4 round engine (reader). Captures the 32 round keys rk0..rk31 as key expansion produces them, one per cycle or with gaps. Replays them one per round on request: forward order for encryption, reverse order for decryption. One key load serves any number of subsequent block passes.

## Interface
- RK_WIDTH, 32: round-key width; fixed for SM4.
- ROUNDS, 32: number of round keys; fixed, index width 5.

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  begin a new key load; discards any stored key set
- rk_wr_en  in  1  rk_wr_data valid this cycle
- rk_wr_data  in  32  round key rk[i], presented in order i=0..31
- key_ready  out  1  full set of 32 round keys stored
- rd_start  in  1  begin a block pass
- rd_dir  in  1  sampled with rd_start: 0 = encrypt (rk0→rk31), 1 = decrypt (rk31→rk0)
- rd_next  in  1  round engine consumed rk_out; advance
- rk_out  out  32  round key for current round, registered
- rk_round  out  5  logical round number 0..31 of rk_out
- rd_busy  out  1  a pass is in progress
- rd_done  out  1  one-cycle pulse after final round key consumed
- err  out  1  one-cycle pulse on any rejected request

## Operation
- Storage: 32×32 register array, written only by the load side.
- Load FSM states:
  - EMPTY: the state after reset.
  - LOADING: entered on load_start; write index wr_idx is cleared to 0.
  - READY: reached after 32 writes.
- Load FSM behaviour:
  - In LOADING, each rk_wr_en writes rk_wr_data to array[wr_idx] and increments wr_idx.
  - The write with wr_idx=31 moves the FSM to READY.
- key_ready = (state == READY).
- Read FSM states:
  - R_IDLE
  - R_RUN: holds rd_idx and the direction latched at start.
- Read start: rd_start is accepted only when key_ready=1 and rd_busy=0.
  - rd_dir=0: rd_idx starts at 0.
  - rd_dir=1: rd_idx starts at 31.
  - rk_round starts at 0 in both directions.
- Read advance: each rd_next in R_RUN increments rk_round. rd_idx moves ±1 per the latched direction.
- Read end: rd_next with rk_round=31 returns the FSM to R_IDLE and pulses rd_done.
- rk_out = array[rd_idx] while in R_RUN; 0 in R_IDLE.
- Rejected requests: each is ignored, with err=1 for one cycle. Several in one cycle still give a single err pulse.
  - rk_wr_en outside LOADING
  - rd_start with key_ready=0
  - rd_start while rd_busy=1
  - load_start while rd_busy=1
- Priority and simultaneous events:
  - load_start together with rk_wr_en in LOADING: restart wins, the write is dropped, no err.
  - load_start while LOADING: restart at wr_idx=0, no err.
  - load_start with rd_start in READY/idle: load wins; rd_start is rejected with err.
  - rd_next in R_IDLE: ignored, no err.
  - rd_next in the same cycle as an accepted rd_start: ignored.
- Reset mid-load or mid-pass: all FSMs go to EMPTY/R_IDLE. Array contents are don't-care and are never readable until a full reload.

## Timing
- Reset values: key_ready=0, rd_busy=0, rd_done=0, err=0, rk_out=0, rk_round=0.
- All outputs are registered; no combinational input→output paths.
- Load:
  - load_start at cycle T gives LOADING at T+1. The first accepted write is at T+1 or later.
  - The 32nd write at cycle W gives key_ready=1 at W+1.
  - Minimum load is 33 cycles from load_start.
- Read:
  - rd_start accepted at T gives rd_busy=1, with rk_out/rk_round valid at T+1.
  - rd_next at cycle N gives the next key on rk_out at N+1. Back-to-back rd_next sustains one key per cycle.
  - rd_next at rk_round=31 in cycle N gives, at N+1: rd_busy=0, rd_done=1, rk_out=0, rk_round=0. rd_done falls at N+2.
  - A new rd_start is accepted at N+1 or later. Fastest pass is 33 cycles start-to-start.
- err is asserted the cycle after the offending request.

## Test plan
- Load and forward read:
  - Stimulus: reset, load_start, then 32 consecutive writes of rk_wr_data = 32'hA5000000+i; rd_start with rd_dir=0, then rd_next every cycle.
  - Response: key_ready rises one cycle after the last write. rk_out steps 32'hA5000000..32'hA500001F with rk_round 0..31. rd_done pulses once, and rd_busy falls in the same cycle.
- Reverse read:
  - Stimulus: same key set; rd_start with rd_dir=1.
  - Response: rk_out steps 32'hA500001F..32'hA5000000 while rk_round counts 0..31. A second pass with rd_dir=0 then returns forward order unchanged.
- Gapped handshake:
  - Stimulus: writes with random idle cycles between them; rd_next with random gaps.
  - Response: rk_out holds each value until the cycle after its rd_next. Sequence is identical to the gap-free case.
- Rejections:
  - rd_start before key_ready gives err=1, rd_busy stays 0.
  - rk_wr_en while READY gives err=1 and array unchanged (next pass still 32'hA5000000 first).
  - load_start while rd_busy gives err, and the pass completes normally.
- Restart and reset:
  - load_start after 10 writes in the same cycle as rk_wr_en, then 32 writes of 32'h5A000000+i: first key read is 32'h5A000000 and no err.
  - rst asserted mid-pass at rk_round=7: next cycle rd_busy=0, key_ready=0, rk_out=0, and rd_start gives err.
